// File: rtl/plru_pkg.sv
// rtl/plru_pkg.sv - shared widths, victim result type and lock-aware tree-PLRU walk
package plru_pkg;

    // Upper bound on associativity handled by the walk helper
    localparam int MAX_WAY   = 64;
    localparam int MAX_WAY_W = 6;

    typedef struct packed {
        logic                 none;
        logic [MAX_WAY_W-1:0] way;
    } vic_t;

    // Way-address width for a given associativity
    function automatic int way_w_of(input int nway);
        return $clog2(nway);
    endfunction

    // Tree bits per set for a given associativity
    function automatic int lru_w_of(input int nway);
        return nway - 1;
    endfunction

    // True when every way under heap node `node` (at tree depth `depth`) is locked
    function automatic logic subtree_locked(
        input int                 node,
        input int                 depth,
        input int                 nway,
        input logic [MAX_WAY-1:0] lock
    );
        logic all_lk;
        int   ww;
        all_lk = 1'b1;
        ww     = way_w_of(nway);
        for (int w = 0; w < MAX_WAY; w++) begin
            if (w < nway && ((w + nway) >> (ww - depth)) == node && !lock[w]) begin
                all_lk = 1'b0;
            end
        end
        return all_lk;
    endfunction

    // Victim choice: lowest invalid unlocked way, else lock-aware PLRU walk,
    // else none when every way is locked
    function automatic vic_t plru_walk(
        input logic [MAX_WAY-2:0] tree,
        input logic [MAX_WAY-1:0] valid,
        input logic [MAX_WAY-1:0] lock,
        input int                 nway
    );
        vic_t r;
        int   ww;
        int   idx;
        int   pick;
        logic all_lk;
        logic found;
        logic b;
        r      = '0;
        ww     = way_w_of(nway);
        all_lk = 1'b1;
        found  = 1'b0;
        idx    = 1;
        for (int w = 0; w < MAX_WAY; w++) begin
            if (w < nway && !lock[w]) begin
                all_lk = 1'b0;
            end
        end
        // Scan downward so the lowest qualifying way is the one left in r.way
        for (int w = MAX_WAY - 1; w >= 0; w--) begin
            if (w < nway && !valid[w] && !lock[w]) begin
                found = 1'b1;
                r.way = MAX_WAY_W'(w);
            end
        end
        if (all_lk) begin
            r.none = 1'b1;
            r.way  = '0;
        end else if (!found) begin
            for (int d = 0; d < MAX_WAY_W; d++) begin
                if (d < ww) begin
                    b = 1'b0;
                    for (int n = 1; n < MAX_WAY; n++) begin
                        if (n == idx) begin
                            b = tree[n-1];
                        end
                    end
                    pick = 2 * idx + (b ? 1 : 0);
                    // A fully locked preferred subtree diverts to its sibling
                    if (subtree_locked(pick, d + 1, nway, lock)) begin
                        pick = 2 * idx + (b ? 0 : 1);
                    end
                    idx = pick;
                end
            end
            r.way = MAX_WAY_W'(idx - nway);
        end
        return r;
    endfunction

endpackage

// File: rtl/plru_tree_touch.sv
// rtl/plru_tree_touch.sv - combinational single-set tree-PLRU path write
module plru_tree_touch
    import plru_pkg::*;
#(
    parameter int NWAY  = 8,
    parameter int WAY_W = $clog2(NWAY),
    parameter int LRU_W = NWAY - 1
) (
    input  logic [LRU_W-1:0] tree_i,
    input  logic [WAY_W-1:0] way_i,
    input  logic             en_i,
    output logic [LRU_W-1:0] tree_o
);

    logic [WAY_W:0] leaf;

    // Leaf index of the touched way in heap numbering
    assign leaf = {1'b1, way_i};

    // Every node on the root-to-leaf path is forced to point away from the way
    always_comb begin
        tree_o = tree_i;
        if (en_i) begin
            for (int d = 0; d < WAY_W; d++) begin
                for (int n = (1 << d); n < (2 << d); n++) begin
                    if (int'(leaf >> (WAY_W - d)) == n) begin
                        tree_o[n-1] = ~way_i[WAY_W-1-d];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/plru_repl_ctrl.sv
// rtl/plru_repl_ctrl.sv - per-set tree-PLRU replacement controller with two touch ports
module plru_repl_ctrl
    import plru_pkg::*;
#(
    parameter int NSET      = 64,
    parameter int NWAY      = 8,
    parameter int VIC_TOUCH = 1,
    parameter int SET_W     = $clog2(NSET),
    parameter int WAY_W     = $clog2(NWAY),
    parameter int LRU_W     = NWAY - 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tch0_vld_i,
    input  logic [SET_W-1:0] tch0_set_i,
    input  logic [WAY_W-1:0] tch0_way_i,
    input  logic             tch1_vld_i,
    input  logic [SET_W-1:0] tch1_set_i,
    input  logic [WAY_W-1:0] tch1_way_i,
    input  logic             vic_req_vld_i,
    output logic             vic_req_rdy_o,
    input  logic [SET_W-1:0] vic_req_set_i,
    input  logic [NWAY-1:0]  vic_req_valid_mask_i,
    input  logic [NWAY-1:0]  vic_req_lock_mask_i,
    output logic             vic_resp_vld_o,
    input  logic             vic_resp_rdy_i,
    output logic [WAY_W-1:0] vic_resp_way_o,
    output logic             vic_resp_none_o
);

    logic [LRU_W-1:0]     tree_q [NSET];

    logic [LRU_W-1:0]     t0_in;
    logic [LRU_W-1:0]     t0_out;
    logic [LRU_W-1:0]     t1_in;
    logic [LRU_W-1:0]     t1_out;
    logic [LRU_W-1:0]     vic_src;
    logic [LRU_W-1:0]     t2_out;
    logic                 acc;
    logic                 at_en;
    vic_t                 vic;
    logic [MAX_WAY_W-1:0] walk_way;
    logic [WAY_W-1:0]     vic_way;
    logic [MAX_WAY-2:0]   tree_x;
    logic [MAX_WAY-1:0]   valid_x;
    logic [MAX_WAY-1:0]   lock_x;

    assign vic_req_rdy_o = ~vic_resp_vld_o | vic_resp_rdy_i;
    assign acc           = vic_req_vld_i & vic_req_rdy_o;

    // Set-match muxes: each stage sees the previous stage's result when on the same set
    assign t0_in   = tree_q[tch0_set_i];
    assign t1_in   = (tch1_set_i == tch0_set_i) ? t0_out : tree_q[tch1_set_i];
    assign vic_src = (vic_req_set_i == tch1_set_i) ? t1_out :
                     (vic_req_set_i == tch0_set_i) ? t0_out : tree_q[vic_req_set_i];

    // Widen the bypassed set state and masks to the walk helper's fixed width
    always_comb begin
        tree_x                = '0;
        valid_x               = '0;
        lock_x                = '0;
        tree_x[LRU_W-1:0]     = vic_src;
        valid_x[NWAY-1:0]     = vic_req_valid_mask_i;
        lock_x[NWAY-1:0]      = vic_req_lock_mask_i;
        vic                   = plru_walk(tree_x, valid_x, lock_x, NWAY);
    end

    assign walk_way = vic.way;
    assign vic_way  = walk_way[WAY_W-1:0];

    generate
        if (WAY_W < MAX_WAY_W) begin : g_walk_hi
            logic walk_hi_unused;
            assign walk_hi_unused = |walk_way[MAX_WAY_W-1:WAY_W];
        end
    endgenerate

    assign at_en = (VIC_TOUCH != 0) && acc && !vic.none;

    plru_tree_touch #(.NWAY(NWAY)) u_tch0 (
        .tree_i (t0_in),
        .way_i  (tch0_way_i),
        .en_i   (tch0_vld_i),
        .tree_o (t0_out)
    );

    plru_tree_touch #(.NWAY(NWAY)) u_tch1 (
        .tree_i (t1_in),
        .way_i  (tch1_way_i),
        .en_i   (tch1_vld_i),
        .tree_o (t1_out)
    );

    plru_tree_touch #(.NWAY(NWAY)) u_vtch (
        .tree_i (vic_src),
        .way_i  (vic_way),
        .en_i   (at_en),
        .tree_o (t2_out)
    );

    // Per-set writeback; later stages already include earlier same-set updates, so last write wins
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < NSET; s++) begin
                tree_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < NSET; s++) begin
                if (tch0_vld_i && tch0_set_i == SET_W'(s)) begin
                    tree_q[s] <= t0_out;
                end
                if (tch1_vld_i && tch1_set_i == SET_W'(s)) begin
                    tree_q[s] <= t1_out;
                end
                if (at_en && vic_req_set_i == SET_W'(s)) begin
                    tree_q[s] <= t2_out;
                end
            end
        end
    end

    // Response register: load on accept, hold while stalled, drop when consumed
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vic_resp_vld_o  <= 1'b0;
            vic_resp_way_o  <= '0;
            vic_resp_none_o <= 1'b0;
        end else if (acc) begin
            vic_resp_vld_o  <= 1'b1;
            vic_resp_way_o  <= vic_way;
            vic_resp_none_o <= vic.none;
        end else if (vic_resp_rdy_i) begin
            vic_resp_vld_o  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_plru_repl_ctrl.sv
// tb/tb_plru_repl_ctrl.sv - directed scoreboard bench for plru_repl_ctrl
module tb_plru_repl_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tch0_vld_i, tch1_vld_i;
    logic [1:0] tch0_set_i, tch1_set_i;
    logic [2:0] tch0_way_i, tch1_way_i;
    logic       vic_req_vld_i, vic_req_rdy_o;
    logic [1:0] vic_req_set_i;
    logic [7:0] vic_req_valid_mask_i, vic_req_lock_mask_i;
    logic       vic_resp_vld_o, vic_resp_rdy_i;
    logic [2:0] vic_resp_way_o;
    logic       vic_resp_none_o;

    logic       nt_req_vld, nt_req_rdy, nt_resp_vld, nt_resp_none;
    logic [2:0] nt_resp_way;

    typedef struct {
        logic [2:0] way;
        logic       none;
    } exp_t;

    exp_t sb[$];
    exp_t pend;
    exp_t got;
    int   n_chk  = 0;
    int   n_fail = 0;
    logic m_vld  = 1'b0;
    logic acc;

    always #5 clk = ~clk;

    plru_repl_ctrl #(.NSET(4), .NWAY(8), .VIC_TOUCH(1)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .tch0_vld_i           (tch0_vld_i),
        .tch0_set_i           (tch0_set_i),
        .tch0_way_i           (tch0_way_i),
        .tch1_vld_i           (tch1_vld_i),
        .tch1_set_i           (tch1_set_i),
        .tch1_way_i           (tch1_way_i),
        .vic_req_vld_i        (vic_req_vld_i),
        .vic_req_rdy_o        (vic_req_rdy_o),
        .vic_req_set_i        (vic_req_set_i),
        .vic_req_valid_mask_i (vic_req_valid_mask_i),
        .vic_req_lock_mask_i  (vic_req_lock_mask_i),
        .vic_resp_vld_o       (vic_resp_vld_o),
        .vic_resp_rdy_i       (vic_resp_rdy_i),
        .vic_resp_way_o       (vic_resp_way_o),
        .vic_resp_none_o      (vic_resp_none_o)
    );

    plru_repl_ctrl #(.NSET(4), .NWAY(8), .VIC_TOUCH(0)) dut_nt (
        .clk                  (clk),
        .rst_n                (rst_n),
        .tch0_vld_i           (tch0_vld_i),
        .tch0_set_i           (tch0_set_i),
        .tch0_way_i           (tch0_way_i),
        .tch1_vld_i           (tch1_vld_i),
        .tch1_set_i           (tch1_set_i),
        .tch1_way_i           (tch1_way_i),
        .vic_req_vld_i        (nt_req_vld),
        .vic_req_rdy_o        (nt_req_rdy),
        .vic_req_set_i        (vic_req_set_i),
        .vic_req_valid_mask_i (vic_req_valid_mask_i),
        .vic_req_lock_mask_i  (vic_req_lock_mask_i),
        .vic_resp_vld_o       (nt_resp_vld),
        .vic_resp_rdy_i       (1'b1),
        .vic_resp_way_o       (nt_resp_way),
        .vic_resp_none_o      (nt_resp_none)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: check handshake/scoreboard at negedge, advance to posedge+1
    task automatic cycle();
        @(negedge clk);
        if (rst_n) begin
            chk("req_rdy", vic_req_rdy_o, !m_vld || vic_resp_rdy_i);
            chk("resp_vld", vic_resp_vld_o, m_vld);
            if (vic_resp_vld_o && vic_resp_rdy_i) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $error("FAIL sb_underflow: observed response way %0d expected none pending", vic_resp_way_o);
                end else begin
                    got = sb.pop_front();
                    chk("resp_way", vic_resp_way_o, got.way);
                    chk("resp_none", vic_resp_none_o, got.none);
                end
            end
            acc = vic_req_vld_i && (!m_vld || vic_resp_rdy_i);
            if (acc) sb.push_back(pend);
            m_vld = acc ? 1'b1 : (vic_resp_rdy_i ? 1'b0 : m_vld);
        end else begin
            m_vld = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [1:0] s, input logic [7:0] v, input logic [7:0] l,
                       input logic [2:0] w, input logic n);
        vic_req_vld_i        = 1'b1;
        vic_req_set_i        = s;
        vic_req_valid_mask_i = v;
        vic_req_lock_mask_i  = l;
        pend.way             = w;
        pend.none            = n;
    endtask

    task automatic idle();
        vic_req_vld_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        tch0_vld_i = 0; tch0_set_i = 0; tch0_way_i = 0;
        tch1_vld_i = 0; tch1_set_i = 0; tch1_way_i = 0;
        vic_req_vld_i = 0; vic_req_set_i = 0;
        vic_req_valid_mask_i = 8'hFF; vic_req_lock_mask_i = 8'h00;
        vic_resp_rdy_i = 1'b1; nt_req_vld = 1'b0;
        pend.way = 0; pend.none = 0;
        cycle();
        cycle();
        rst_n = 1'b1;
        chk("rst_vld", vic_resp_vld_o, 0);
        chk("rst_way", vic_resp_way_o, 0);
        chk("rst_none", vic_resp_none_o, 0);
        chk("rst_rdy", vic_req_rdy_o, 1);
        for (int s = 0; s < 4; s++) chk("rst_tree", dut.tree_q[s], 0);

        // Bypass: no-auto-touch instance sees same-cycle tch0 on set 2
        tch0_vld_i = 1; tch0_set_i = 2; tch0_way_i = 0;
        nt_req_vld = 1; vic_req_set_i = 2;
        vic_req_valid_mask_i = 8'hFF; vic_req_lock_mask_i = 8'h00;
        cycle();
        tch0_vld_i = 0; nt_req_vld = 0;
        chk("byp_vld", nt_resp_vld, 1);
        chk("byp_way", nt_resp_way, 4);
        chk("byp_none", nt_resp_none, 0);
        chk("byp_tree_nt", dut_nt.tree_q[2], 7'b0001011);
        chk("byp_tree", dut.tree_q[2], 7'b0001011);

        // Spread: back-to-back misses to set 0
        req(0, 8'hFF, 8'h00, 0, 0); cycle();
        req(0, 8'hFF, 8'h00, 4, 0); cycle();
        req(0, 8'hFF, 8'h00, 2, 0); cycle();
        req(0, 8'hFF, 8'h00, 6, 0); cycle();
        idle(); cycle();
        chk("spread_tree", dut.tree_q[0], 7'b1111000);

        // Locks on set 3 from reset state
        req(3, 8'hFF, 8'h0F, 4, 0); cycle();
        req(3, 8'hFF, 8'hFF, 0, 1); cycle();
        idle(); cycle();
        chk("lock_tree", dut.tree_q[3], 7'b0100100);

        // Invalid way wins over the walk
        req(3, 8'b1111_0111, 8'h00, 3, 0); cycle();
        idle(); cycle();
        chk("inv_tree", dut.tree_q[3], 7'b0100101);

        // Same-set dual touch on set 1
        tch0_vld_i = 1; tch0_set_i = 1; tch0_way_i = 0;
        tch1_vld_i = 1; tch1_set_i = 1; tch1_way_i = 7;
        cycle();
        tch0_vld_i = 0; tch1_vld_i = 0;
        chk("dual_tree", dut.tree_q[1], 7'b0001010);
        req(1, 8'hFF, 8'h00, 2, 0); cycle();
        idle(); cycle();

        // Backpressure with a touch during the stall
        vic_resp_rdy_i = 0;
        req(0, 8'hFF, 8'h00, 1, 0); cycle();
        tch0_vld_i = 1; tch0_set_i = 0; tch0_way_i = 7;
        req(0, 8'hFF, 8'h00, 3, 0); cycle();
        chk("stall_way1", vic_resp_way_o, 1);
        tch0_vld_i = 0;
        cycle();
        chk("stall_way2", vic_resp_way_o, 1);
        cycle();
        chk("stall_way3", vic_resp_way_o, 1);
        chk("stall_none", vic_resp_none_o, 0);
        vic_resp_rdy_i = 1; cycle();
        idle(); cycle();

        // Reset in the middle of a stall drops the response
        vic_resp_rdy_i = 0;
        req(2, 8'hFF, 8'h00, 4, 0); cycle();
        idle(); cycle();
        chk("stall2_way", vic_resp_way_o, 4);
        rst_n = 0; cycle();
        sb.delete();
        chk("mrst_vld", vic_resp_vld_o, 0);
        chk("mrst_way", vic_resp_way_o, 0);
        chk("mrst_none", vic_resp_none_o, 0);
        for (int s = 0; s < 4; s++) chk("mrst_tree", dut.tree_q[s], 0);
        rst_n = 1; vic_resp_rdy_i = 1;
        req(0, 8'hFF, 8'h00, 0, 0); cycle();
        idle(); cycle();
        chk("sb_drain", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/plru_repl_ctrl.md
# plru_repl_ctrl

Per-set tree-PLRU replacement controller for the L1D. Holds `NSET` tree-PLRU states of `NWAY-1` bits each and accepts two touch streams per cycle: port 0 from the load-pipe hit path, port 1 from the store/refill path. It answers victim requests with a registered, back-pressurable response. Victim selection respects a per-way valid mask and lock mask, and optionally auto-touches the chosen way so back-to-back misses to one set spread across ways.

## Interface
- `NSET`, 64, number of sets; power of two, ≥2
- `NWAY`, 8, ways per set; power of two, ≥2
- `VIC_TOUCH`, 1, 1 = auto-touch the victim on request accept
- `SET_W`, `$clog2(NSET)`, derived
- `WAY_W`, `$clog2(NWAY)`, derived
- `LRU_W`, `NWAY-1`, derived
- `clk`  in  1  clock
- `rst_n`  in  1  reset; synchronous, active-low
- `tch0_vld_i`  in  1  touch port 0 valid
- `tch0_set_i`  in  SET_W  touch port 0 set
- `tch0_way_i`  in  WAY_W  touch port 0 way
- `tch1_vld_i`, `tch1_set_i`, `tch1_way_i`  in  1/SET_W/WAY_W  touch port 1; same meaning as port 0
- `vic_req_vld_i`  in  1  victim request valid
- `vic_req_rdy_o`  out  1  victim request ready
- `vic_req_set_i`  in  SET_W  set to choose a victim from
- `vic_req_valid_mask_i`  in  NWAY  1 = way holds a valid line
- `vic_req_lock_mask_i`  in  NWAY  1 = way must not be chosen
- `vic_resp_vld_o`  out  1  response valid
- `vic_resp_rdy_i`  in  1  response ready
- `vic_resp_way_o`  out  WAY_W  chosen way
- `vic_resp_none_o`  out  1  every way is locked; no victim exists

## Operation
- Tree encoding:
  - Node `idx` is heap-numbered: root = 1, children `2*idx`, `2*idx+1`.
  - Node `idx` is stored in bit `idx-1`.
  - Way address bits are consumed MSB first.
- Touch way `w`:
  - At each level `i` from `WAY_W-1` down to 0, set the node on the path to `~w[i]`. The node then points away from `w`.
  - Descend to `2*idx + w[i]`.
  - Touch is a deterministic write, not a toggle.
- Victim walk:
  - From the root, descend to `2*idx + bit[idx-1]`.
  - Leaf `idx` gives way `idx - NWAY`.
  - If the subtree chosen at a node is entirely locked, take the other child instead.
- Victim priority:
  1. The lowest-index way that is invalid and unlocked.
  2. Otherwise the lock-aware PLRU walk.
  3. If all ways are locked: `none=1`, `way=0`.
- Update order within one cycle, applied sequentially to the same set: tch0, then tch1, then victim auto-touch.
  - Touches to different sets are applied independently.
  - When tch0 and tch1 hit the same set, the nodes written by tch1 win.
- Bypass:
  - The victim is computed from the set state after the same-cycle tch0/tch1 updates.
  - The victim does not see its own auto-touch.
- Auto-touch (`VIC_TOUCH=1`):
  - Applied on accept only.
  - Skipped when `none=1`.
- Request handshake:
  - `vic_req_rdy_o = ~vic_resp_vld_o | vic_resp_rdy_i`.
  - A request is accepted when `vld & rdy`.
- Touches are always accepted; they have no ready.

## Timing
- Reset (`rst_n=0` at a clock edge):
  - All tree bits go to 0.
  - `vic_resp_vld_o=0`, `vic_resp_way_o=0`, `vic_resp_none_o=0`.
  - Any pending response is dropped.
- A touch in cycle N is visible to state reads in cycle N+1, and to a victim request in cycle N via the bypass.
- Victim latency: request accepted in cycle N → `vic_resp_vld_o=1` in cycle N+1.
- Response with `vic_resp_rdy_i=0`:
  - `vld`, `way` and `none` are held stable.
  - `vic_req_rdy_o` is low.
  - Touches continue to update state.
- Response with `vic_resp_rdy_i=1`: a new request may be accepted in the same cycle (full throughput).
- Auto-touch of cycle N is visible from cycle N+1.

## Structure
- Package `plru_pkg` holds:
  - Width helpers.
  - A pure function `plru_walk(tree, valid, lock)`.
- Sub-module `plru_tree_touch`: combinational single-set path write, taking `tree_i`, `way_i`, `en_i` and producing `tree_o`.
  - Three instances are chained: tch0 → tch1 → auto-touch.
  - Each stage uses a set-match mux in front of it.
- State is a flop array `[NSET][LRU_W]`. The response register is the only other state.

## Test plan
Configuration: `NWAY=8`, `NSET=4`, `VIC_TOUCH=1`.
- Spread: after reset, 4 back-to-back requests to set 0, all valid, no locks → ways 0, 4, 2, 6 on consecutive cycles, `none=0`.
- Invalid first: valid `8'b1111_0111` → way 3; state unchanged apart from the auto-touch.
- Locks:
  - From reset state, all valid, lock `8'b0000_1111` → way 4.
  - Lock `8'hFF` → `none=1`, `way=0`, and the state of the set is unchanged.
- Same-set dual touch:
  - From reset, tch0 (set 1, way 0) and tch1 (set 1, way 7) in one cycle.
  - Set 1 bits then read `bit0=0, bit1=1, bit3=1, bit2=0, bit6=0`.
  - A later request → way 2.
- Bypass: `VIC_TOUCH=0`, from reset, request set 2 in the same cycle as tch0 (set 2, way 0) → way 4.
- Backpressure and reset:
  - Hold `vic_resp_rdy_i=0` for 3 cycles → response stable, `req_rdy=0`.
  - Touches made during the stall are visible to the next request.
  - Assert `rst_n=0` mid-stall → `resp_vld=0` next cycle and all set states return to 0.
